// File: rtl/sram_pkg.sv
// Shared constants and the byte-merge helper for the dual-port SRAM model.
// be_merge works on a fixed maximum width; callers size-cast in and out.
package sram_pkg;
    localparam int RDW_OLD     = 0;
    localparam int RDW_NEW     = 1;
    localparam int RD_LAT_MAX  = 4;
    localparam int MERGE_W_MAX = 256;
    localparam int MERGE_BE_MAX = MERGE_W_MAX / 8;

    function automatic logic [MERGE_W_MAX-1:0] be_merge(
        input logic [MERGE_W_MAX-1:0]  old_w,
        input logic [MERGE_W_MAX-1:0]  new_w,
        input logic [MERGE_BE_MAX-1:0] be
    );
        logic [MERGE_W_MAX-1:0] res;
        res = old_w;
        for (int i = 0; i < MERGE_BE_MAX; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction
endpackage

// File: rtl/sram_dp_model_rd_pipe.sv
// Per-port read pipeline: RD_LAT stages of {valid, data}; the last stage is
// the dout register, which only loads on a delivered read and so holds between reads.
module sram_rd_pipe
    import sram_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int WIDTH  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             vld
);
    logic [RD_LAT-1:0] v_sr;
    logic [WIDTH-1:0]  d_sr [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_sr <= '0;
            for (int i = 0; i < RD_LAT; i++) d_sr[i] <= '0;
        end else begin
            v_sr[0] <= issue;
            if (issue) d_sr[0] <= din;
            for (int i = 1; i < RD_LAT; i++) begin
                v_sr[i] <= v_sr[i-1];
                if (v_sr[i-1]) d_sr[i] <= d_sr[i-1];
            end
        end
    end

    assign vld  = v_sr[RD_LAT-1];
    assign dout = d_sr[RD_LAT-1];
endmodule

// File: rtl/sram_dp_model.sv
// True dual-port behavioural SRAM: byte-enable writes, pipelined reads,
// selectable cross-port read-during-write, and same-address write collision counting.
module sram_dp_model
    import sram_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int WIDTH     = 32,
    parameter int DEPTH_LOG = $clog2(DEPTH),
    parameter int BE_W      = WIDTH / 8,
    parameter int RD_LAT    = 1,
    parameter int RDW_MODE  = RDW_OLD,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cs_a,
    input  logic                 we_a,
    input  logic [BE_W-1:0]      be_a,
    input  logic [DEPTH_LOG-1:0] ad_a,
    input  logic [WIDTH-1:0]     din_a,
    output logic [WIDTH-1:0]     dout_a,
    output logic                 vld_a,
    input  logic                 cs_b,
    input  logic                 we_b,
    input  logic [BE_W-1:0]      be_b,
    input  logic [DEPTH_LOG-1:0] ad_b,
    input  logic [WIDTH-1:0]     din_b,
    output logic [WIDTH-1:0]     dout_b,
    output logic                 vld_b,
    output logic                 coll,
    output logic [CNT_W-1:0]     coll_cnt
);
    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("sram_dp_model: RD_LAT=%0d outside 1..%0d", RD_LAT, RD_LAT_MAX);
    end
    if (WIDTH % 8 != 0 || WIDTH > MERGE_W_MAX) begin : g_bad_width
        $error("sram_dp_model: WIDTH=%0d must be a multiple of 8 up to %0d", WIDTH, MERGE_W_MAX);
    end

    // Zeroed once at time 0; rst_n never touches the array.
    logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic             inr_a, inr_b, wr_a, wr_b, rd_a, rd_b, same_ad, coll_now;
    logic [WIDTH-1:0] old_a, old_b, wdata_a, wdata_b, rdata_a, rdata_b;

    if (DEPTH == 2 ** DEPTH_LOG) begin : g_full_range
        assign inr_a = 1'b1;
        assign inr_b = 1'b1;
    end else begin : g_part_range
        assign inr_a = int'(ad_a) < DEPTH;
        assign inr_b = int'(ad_b) < DEPTH;
        assert property (@(posedge clk) disable iff (!rst_n) !(cs_a && !inr_a))
            else $warning("sram_dp_model: port A address %0d out of range", ad_a);
        assert property (@(posedge clk) disable iff (!rst_n) !(cs_b && !inr_b))
            else $warning("sram_dp_model: port B address %0d out of range", ad_b);
    end

    assign wr_a    = cs_a & we_a & inr_a;
    assign wr_b    = cs_b & we_b & inr_b;
    assign rd_a    = cs_a & ~we_a;
    assign rd_b    = cs_b & ~we_b;
    assign same_ad = (ad_a == ad_b);
    assign old_a   = inr_a ? mem[ad_a] : '0;
    assign old_b   = inr_b ? mem[ad_b] : '0;

    // Port A is merged on top of port B's result so A wins every overlapping byte.
    assign wdata_b = WIDTH'(be_merge(MERGE_W_MAX'(old_b), MERGE_W_MAX'(din_b), MERGE_BE_MAX'(be_b)));
    assign wdata_a = WIDTH'(be_merge(MERGE_W_MAX'((wr_b && same_ad) ? wdata_b : old_a),
                                     MERGE_W_MAX'(din_a), MERGE_BE_MAX'(be_a)));

    assign rdata_a = (RDW_MODE == RDW_NEW && wr_b && same_ad) ? wdata_b : old_a;
    assign rdata_b = (RDW_MODE == RDW_NEW && wr_a && same_ad) ? wdata_a : old_b;

    assign coll_now = wr_a & wr_b & same_ad & (|(be_a & be_b));

    always_ff @(posedge clk) begin
        if (wr_a) mem[ad_a] <= wdata_a;
        if (wr_b && !(wr_a && same_ad)) mem[ad_b] <= wdata_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll     <= 1'b0;
            coll_cnt <= '0;
        end else begin
            coll <= coll_now;
            if (coll_now && coll_cnt != '1) coll_cnt <= coll_cnt + CNT_W'(1);
        end
    end

    sram_rd_pipe #(.RD_LAT(RD_LAT), .WIDTH(WIDTH)) u_pipe_a (
        .clk(clk), .rst_n(rst_n), .issue(rd_a), .din(rdata_a), .dout(dout_a), .vld(vld_a)
    );

    sram_rd_pipe #(.RD_LAT(RD_LAT), .WIDTH(WIDTH)) u_pipe_b (
        .clk(clk), .rst_n(rst_n), .issue(rd_b), .din(rdata_b), .dout(dout_b), .vld(vld_b)
    );
endmodule

// File: tb/tb_sram_dp_model.sv
// Scoreboard bench: three model instances (RD_LAT 1/3/4, RDW old/new/old, CNT_W=3)
// share one stimulus stream; a monitor pops expected reads as vld strobes arrive.
module tb_sram_dp_model;
    localparam int NI = 3;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic       cs_a = 1'b0, we_a = 1'b0, cs_b = 1'b0, we_b = 1'b0;
    logic [3:0] be_a = '0, be_b = '0;
    logic [2:0] ad_a = '0, ad_b = '0;
    logic [31:0] din_a = '0, din_b = '0;

    logic [NI-1:0][31:0] dout_a_w, dout_b_w;
    logic [NI-1:0]       vld_a_w, vld_b_w, coll_w;
    logic [NI-1:0][2:0]  cnt_w;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    exp_t        sb [2*NI][$];
    logic [31:0] last_exp [2*NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sram_dp_model #(
            .DEPTH(8), .WIDTH(32),
            .RD_LAT((g == 0) ? 1 : (g == 1) ? 3 : 4),
            .RDW_MODE((g == 1) ? 1 : 0),
            .CNT_W(3)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .cs_a(cs_a), .we_a(we_a), .be_a(be_a), .ad_a(ad_a), .din_a(din_a),
            .dout_a(dout_a_w[g]), .vld_a(vld_a_w[g]),
            .cs_b(cs_b), .we_b(we_b), .be_b(be_b), .ad_b(ad_b), .din_b(din_b),
            .dout_b(dout_b_w[g]), .vld_b(vld_b_w[g]),
            .coll(coll_w[g]), .coll_cnt(cnt_w[g])
        );
    end

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 3 : 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic ca, input logic wa, input logic [3:0] ba, input logic [2:0] aa,
                         input logic [31:0] da, input logic cb, input logic wb, input logic [3:0] bb,
                         input logic [2:0] ab, input logic [31:0] db);
        @(negedge clk);
        cs_a = ca; we_a = wa; be_a = ba; ad_a = aa; din_a = da;
        cs_b = cb; we_b = wb; be_b = bb; ad_b = ab; din_b = db;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 4'h0, 3'd0, 32'h0, 0, 0, 4'h0, 3'd0, 32'h0);
    endtask

    // Expected read for port p; old_d for RDW-old instances, new_d for the RDW-new one.
    task automatic push_rd(input int p, input logic [31:0] old_d, input logic [31:0] new_d);
        exp_t e;
        for (int g = 0; g < NI; g++) begin
            e.due  = cyc + lat_of(g);
            e.data = (g == 1) ? new_d : old_d;
            sb[g*2+p].push_back(e);
        end
    endtask

    task automatic rd(input int p, input logic [2:0] ad, input logic [31:0] old_d, input logic [31:0] new_d);
        if (p == 0) drive(1, 0, 4'h0, ad, 32'h0, 0, 0, 4'h0, 3'd0, 32'h0);
        else        drive(0, 0, 4'h0, 3'd0, 32'h0, 1, 0, 4'h0, ad, 32'h0);
        push_rd(p, old_d, new_d);
    endtask

    task automatic chk_coll(input string tag, input logic exp_coll, input logic [2:0] exp_cnt);
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("%s coll i%0d", tag, g), 32'(coll_w[g]), 32'(exp_coll));
            chk($sformatf("%s coll_cnt i%0d", tag, g), 32'(cnt_w[g]), 32'(exp_cnt));
        end
    endtask

    // Monitor
    initial begin
        int          k;
        logic        v;
        logic [31:0] d;
        exp_t        e;
        for (int i = 0; i < 2*NI; i++) last_exp[i] = '0;
        forever begin
            @(negedge clk);
            for (int g = 0; g < NI; g++) begin
                for (int p = 0; p < 2; p++) begin
                    k = g*2 + p;
                    v = (p == 0) ? vld_a_w[g] : vld_b_w[g];
                    d = (p == 0) ? dout_a_w[g] : dout_b_w[g];
                    if (!rst_n) begin
                        sb[k].delete();
                        last_exp[k] = '0;
                        chk($sformatf("rst vld i%0d p%0d", g, p), 32'(v), 32'h0);
                        chk($sformatf("rst dout i%0d p%0d", g, p), d, 32'h0);
                        if (p == 0) begin
                            chk($sformatf("rst coll i%0d", g), 32'(coll_w[g]), 32'h0);
                            chk($sformatf("rst coll_cnt i%0d", g), 32'(cnt_w[g]), 32'h0);
                        end
                    end else if (v) begin
                        if (sb[k].size() == 0) begin
                            chk($sformatf("spurious vld i%0d p%0d", g, p), 32'(v), 32'h0);
                        end else begin
                            e = sb[k].pop_front();
                            chk($sformatf("rd cycle i%0d p%0d", g, p), cyc, e.due);
                            chk($sformatf("rd data i%0d p%0d", g, p), d, e.data);
                            last_exp[k] = e.data;
                        end
                    end else begin
                        chk($sformatf("dout hold i%0d p%0d", g, p), d, last_exp[k]);
                        if (sb[k].size() > 0 && sb[k][0].due <= cyc) begin
                            chk($sformatf("missing vld i%0d p%0d", g, p), 32'(v), 32'h1);
                            void'(sb[k].pop_front());
                        end
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        chk_coll("post-reset", 1'b0, 3'd0);

        rd(0, 3'd0, 32'h0, 32'h0);                                   // zeroed at time 0
        drive(1, 1, 4'hF, 3'd3, 32'hDEADBEEF, 0, 0, 4'h0, 3'd0, 32'h0);
        rd(0, 3'd3, 32'hDEADBEEF, 32'hDEADBEEF);
        idle(6);

        drive(1, 1, 4'hF, 3'd2, 32'h11223344, 0, 0, 4'h0, 3'd0, 32'h0);
        drive(0, 0, 4'h0, 3'd0, 32'h0, 1, 1, 4'b0101, 3'd2, 32'hAABBCCDD);
        rd(1, 3'd2, 32'h11BB33DD, 32'h11BB33DD);
        idle(5);

        drive(1, 1, 4'hF, 3'd0, 32'h10, 1, 1, 4'hF, 3'd1, 32'h20);    // independent addresses
        drive(1, 1, 4'hF, 3'd2, 32'h30, 0, 0, 4'h0, 3'd0, 32'h0);
        chk_coll("diff addr", 1'b0, 3'd0);
        rd(0, 3'd0, 32'h10, 32'h10);
        drive(1, 0, 4'h0, 3'd1, 32'h0, 1, 0, 4'h0, 3'd3, 32'h0);
        push_rd(0, 32'h20, 32'h20);
        push_rd(1, 32'hDEADBEEF, 32'hDEADBEEF);
        rd(0, 3'd2, 32'h30, 32'h30);
        idle(5);

        drive(1, 1, 4'h0, 3'd0, 32'hFFFFFFFF, 0, 0, 4'h0, 3'd0, 32'h0); // be=0 is a no-op
        rd(0, 3'd0, 32'h10, 32'h10);
        idle(5);

        drive(1, 1, 4'h1, 3'd5, 32'h000000AA, 1, 1, 4'h3, 3'd5, 32'h0000BBBB);
        idle(1);
        chk_coll("first collision", 1'b1, 3'd1);
        idle(1);
        chk_coll("coll one-shot", 1'b0, 3'd1);
        rd(0, 3'd5, 32'h0000BBAA, 32'h0000BBAA);
        drive(1, 1, 4'h1, 3'd6, 32'h00000011, 1, 1, 4'h2, 3'd6, 32'h00002200); // disjoint bytes
        idle(1);
        chk_coll("disjoint be", 1'b0, 3'd1);
        rd(1, 3'd6, 32'h00002211, 32'h00002211);
        idle(5);

        repeat (10) drive(1, 1, 4'h1, 3'd5, 32'h000000AA, 1, 1, 4'h3, 3'd5, 32'h0000BBBB);
        idle(1);
        chk_coll("saturated", 1'b1, 3'd7);
        idle(1);
        chk_coll("saturated hold", 1'b0, 3'd7);

        drive(1, 1, 4'hF, 3'd4, 32'h1, 0, 0, 4'h0, 3'd0, 32'h0);
        drive(1, 1, 4'hF, 3'd4, 32'h2, 1, 0, 4'h0, 3'd4, 32'h0);     // A writes, B reads
        push_rd(1, 32'h1, 32'h2);
        drive(1, 0, 4'h0, 3'd4, 32'h0, 1, 1, 4'b0010, 3'd4, 32'h00005500); // B writes, A reads
        push_rd(0, 32'h2, 32'h00005502);
        chk_coll("rdw", 1'b0, 3'd7);
        idle(1);
        chk_coll("rdw second", 1'b0, 3'd7);
        rd(1, 3'd4, 32'h00005502, 32'h00005502);
        idle(6);

        rd(0, 3'd3, 32'hDEADBEEF, 32'hDEADBEEF);                     // only RD_LAT=1 delivers
        idle(1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(7);
        chk_coll("after mid reset", 1'b0, 3'd0);
        rd(0, 3'd3, 32'hDEADBEEF, 32'hDEADBEEF);
        rd(1, 3'd5, 32'h0000BBAA, 32'h0000BBAA);
        idle(8);

        for (int k = 0; k < 2*NI; k++) chk($sformatf("pending reads q%0d", k), sb[k].size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sram_dp_model.md
Name: sram_dp_model

Overview:
- Behavioural true dual-port SRAM model. It is the parametrised successor of the single-port sram_model.
- Adds two independent ports (A, B), byte-enable writes, configurable read latency with a read-valid strobe, selectable read-during-write policy, and collision detection/counting.
- Used in simulation as the memory behind bus slaves and DMA testbenches. Must also be synthesisable as registers.

Parameters:
- DEPTH, 8, number of words
- WIDTH, 32, word width in bits; must be a multiple of 8
- DEPTH_LOG, $clog2(DEPTH), address width
- BE_W, WIDTH/8, byte-enable width
- RD_LAT, 1, read latency in cycles; legal 1..4; elaboration error otherwise
- RDW_MODE, 0, cross-port read-during-write policy: 0 = old data, 1 = new data
- CNT_W, 16, collision counter width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- cs_a  in  1  port A chip select
- we_a  in  1  port A write enable (effective only with cs_a)
- be_a  in  BE_W  port A byte enables; bit i covers din_a[8i+7:8i]
- ad_a  in  DEPTH_LOG  port A address
- din_a  in  WIDTH  port A write data
- dout_a  out  WIDTH  port A read data
- vld_a  out  1  port A read-data-valid strobe
- cs_b, we_b, be_b, ad_b, din_b, dout_b, vld_b: same as port A, for port B
- coll  out  1  one-cycle pulse: both ports wrote the same address in the same cycle
- coll_cnt  out  CNT_W  saturating count of coll events

Behaviour:
- Reset (async assert, sync-released by the environment):
  - dout_a/dout_b = 0, vld_a/vld_b = 0, coll = 0, coll_cnt = 0.
  - All read pipeline stages are cleared.
  - Memory contents are NOT affected by rst_n.
  - Memory is zeroed once at time 0.
- Per-port operation each cycle:
  - cs & we: write. Only bytes with be[i]=1 are updated. A write with be=0 is a no-op. No read is issued; dout holds its value; no vld.
  - cs & !we: read issued. Data appears on dout with vld=1 exactly RD_LAT cycles after the issuing edge. RD_LAT=1 matches the old single-port timing.
  - !cs: idle.
- Read pipeline:
  - Each port has an RD_LAT-deep shift pipeline of {valid, data}. Data is sampled from the array at the issue edge.
  - One read may issue per port per cycle (fully pipelined); back-to-back reads yield back-to-back vld.
  - dout holds the last delivered value when vld=0 and is never cleared except by reset.
- Same address, same cycle, both ports writing:
  - Port A data is written for every byte where be_a=1.
  - Port B writes only bytes where be_a=0 and be_b=1.
  - coll=1 for one cycle if be_a & be_b is nonzero. The array update itself completes in that same cycle.
  - coll_cnt increments by 1 and saturates at 2^CNT_W-1.
- One port reads and the other writes the same address in the same cycle:
  - RDW_MODE=0: the read returns pre-write data.
  - RDW_MODE=1: the read returns the merged post-write word (bytes with be=1 take new data).
  - Not a collision; coll stays 0.
- Different addresses: ports are fully independent.
- Address range: ad >= DEPTH (when DEPTH is not a power of two) makes a read return 0 and a write do nothing. A simulation warning is raised.
- Reset mid-operation: in-flight reads are discarded, and no vld appears after reset release for reads issued before it. A write sampled on the same edge that reset asserts is not guaranteed.

Decomposition:
- Package sram_pkg:
  - RDW_OLD=0 / RDW_NEW=1 constants
  - RD_LAT_MAX=4
  - function be_merge(old, new, be) returning the byte-merged word
- Sub-module sram_rd_pipe, instantiated once per port:
  - parametrised RD_LAT, WIDTH
  - input issue/data; output dout/vld
  - holds the async-reset pipeline and the dout hold register
- The array, write arbitration and collision counter stay in the top.

Test Plan:
- RD_LAT=1: A writes 0xDEADBEEF to addr 3 (be=4'hF), then A reads addr 3 → next cycle dout_a=0xDEADBEEF, vld_a=1 for one cycle; dout_a holds afterwards with vld_a=0.
- Byte enables: addr 2 holds 0x11223344; B writes 0xAABBCCDD with be=4'b0101 → B read returns 0x11BB33DD.
- RD_LAT=3: A reads addrs 0,1,2 back-to-back (contents 0x10, 0x20, 0x30) → vld_a high on cycles 3, 4, 5 after the first issue, with dout_a=0x10, 0x20, 0x30.
- Collision: A writes 0x000000AA with be=4'h1, B writes 0x0000BBBB with be=4'h3, both to addr 5 → mem[5]=0x0000BBAA; coll pulses once; coll_cnt=1. Repeat 2^CNT_W+2 times → coll_cnt saturates at all-ones.
- Read-during-write: mem[4]=0x1; A writes 0x2 to addr 4 while B reads addr 4 → B gets 0x1 with RDW_MODE=0, 0x2 with RDW_MODE=1; coll=0.
- Reset mid-read: RD_LAT=4, issue a read, assert rst_n=0 two cycles later for one cycle → dout=0 and vld=0 immediately; no vld after release; memory contents preserved on a later read.
